// File: rtl/fpu_addsub_pkg.sv
// Shared constants, special values and FSM state encoding for the
// single-precision add/subtract unit.
package fpu_defs;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic exp_all_ones(input logic [31:0] v);
    return v[30:23] == EXP_W'(EXP_MAX);
  endfunction

endpackage

// File: rtl/fpu_addsub_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input reports 25.
module fp_lzc (
  input  logic [24:0] val,
  output logic [4:0]  cnt
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    cnt = 5'd25;
    for (int unsigned i = 0; i < 25; i++) begin
      if (val[i]) cnt = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle single-precision add/subtract: truncating rounding, denormals
// flushed to zero, write-back triple presented one cycle after DONE.
module fpu_addsub
  import fpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  dest_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  dest_out,
  output logic        reg_write
);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               op_q, op_d;
  logic [4:0]         dest_q, dest_d;
  logic               sign_q, sign_d, sub_q, sub_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        big_q, big_d, small_q, small_d, sum_q, sum_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_val_q, spec_val_d, res_q, res_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         dest_out_q, dest_out_d;
  logic               done_q, done_d;

  // Unpack and align signals
  logic [7:0]         a_exp, b_exp, big_exp, small_exp, exp_diff;
  logic [23:0]        a_man, b_man, big_man, small_man;
  logic               sa, sb, a_ge_b, a_nan, b_nan, a_inf, b_inf;
  logic [24:0]        small_sh;
  logic               al_spec;
  logic [31:0]        al_spec_val;

  // Normalise signals
  logic [4:0]         lz, norm_shift;
  logic [22:0]        norm_man;
  logic signed [9:0]  norm_exp;
  logic [31:0]        res_norm;

  always_comb begin
    a_exp     = a_q[30:23];
    b_exp     = b_q[30:23];
    a_man     = (a_exp == '0) ? '0 : {1'b1, a_q[22:0]};
    b_man     = (b_exp == '0) ? '0 : {1'b1, b_q[22:0]};
    sa        = a_q[31];
    sb        = b_q[31] ^ op_q;
    a_nan     = exp_all_ones(a_q) && (a_q[22:0] != '0);
    b_nan     = exp_all_ones(b_q) && (b_q[22:0] != '0);
    a_inf     = exp_all_ones(a_q) && (a_q[22:0] == '0);
    b_inf     = exp_all_ones(b_q) && (b_q[22:0] == '0);
    a_ge_b    = {a_exp, a_man} >= {b_exp, b_man};
    big_exp   = a_ge_b ? a_exp : b_exp;
    small_exp = a_ge_b ? b_exp : a_exp;
    big_man   = a_ge_b ? a_man : b_man;
    small_man = a_ge_b ? b_man : a_man;
    exp_diff  = big_exp - small_exp;
    small_sh  = (exp_diff >= 8'd26) ? '0 : ({1'b0, small_man} >> exp_diff);

    al_spec     = 1'b1;
    al_spec_val = '0;
    if (a_nan || b_nan)         al_spec_val = QNAN;
    else if (a_inf && b_inf)    al_spec_val = (sa != sb) ? QNAN : (sa ? NEG_INF : POS_INF);
    else if (a_inf)             al_spec_val = sa ? NEG_INF : POS_INF;
    else if (b_inf)             al_spec_val = sb ? NEG_INF : POS_INF;
    else if (a_exp == '0 && b_exp == '0) al_spec_val = {sa & sb, 31'b0};
    else                        al_spec = 1'b0;
  end

  fp_lzc u_lzc (
    .val (sum_q),
    .cnt (lz)
  );

  // Without a carry the leading one belongs at bit 23, one below the 25-bit MSB.
  always_comb begin
    norm_shift = lz - 5'd1;
    if (sum_q[24]) begin
      norm_man = sum_q[23:1];
      norm_exp = exp_q + 10'sd1;
    end else begin
      norm_man = 23'(sum_q << norm_shift);
      norm_exp = exp_q - $signed({5'b0, norm_shift});
    end

    if (spec_q)                   res_norm = spec_val_q;
    else if (sum_q == '0)         res_norm = '0;
    else if (norm_exp >= 10'sd255) res_norm = sign_q ? NEG_INF : POS_INF;
    else if (norm_exp <= 10'sd0)  res_norm = {sign_q, 31'b0};
    else                          res_norm = {sign_q, norm_exp[7:0], norm_man};
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    dest_d     = dest_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    exp_d      = exp_q;
    big_d      = big_q;
    small_d    = small_q;
    sum_d      = sum_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    res_d      = res_q;
    result_d   = result_q;
    dest_out_d = dest_out_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          dest_d  = dest_in;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        sign_d     = a_ge_b ? sa : sb;
        sub_d      = sa ^ sb;
        exp_d      = {2'b00, big_exp};
        big_d      = {1'b0, big_man};
        small_d    = small_sh;
        spec_d     = al_spec;
        spec_val_d = al_spec_val;
        state_d    = ADD;
      end
      ADD: begin
        sum_d   = sub_q ? (big_q - small_q) : (big_q + small_q);
        state_d = NORM;
      end
      NORM: begin
        res_d   = res_norm;
        state_d = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        result_d   = res_q;
        dest_out_d = dest_q;
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          dest_d  = dest_in;
          state_d = ALIGN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      dest_q     <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      sum_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      res_q      <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      exp_q      <= exp_d;
      big_q      <= big_d;
      small_q    <= small_d;
      sum_q      <= sum_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      res_q      <= res_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q == ALIGN) || (state_q == ADD) || (state_q == NORM);
  assign done      = done_q;
  assign result    = result_q;
  assign dest_out  = dest_out_q;
  assign reg_write = done_q && (dest_out_q != '0);

endmodule

// File: tb/tb_fpu_addsub.sv
// Bench for fpu_addsub: value-level float model plus timing model, checked
// every cycle, with directed vectors pinned to hand-computed results.
module tb_fpu_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  dest_in = '0;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  dest_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  fpu_addsub dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .dest_in   (dest_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dest_out  (dest_out),
    .reg_write (reg_write)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, want);
    end
  endtask

  // Value model: real-number style reasoning on integer mantissas.
  function automatic logic [31:0] fp_model(input logic [31:0] x, input logic [31:0] y,
                                           input logic sub);
    int     ex, ey, ebig, esml, e, d;
    longint mx, my, mbig, msml, r;
    logic   sx, sy, s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = y[31] ^ sub;
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC0_0000;
    if (ex == 255 && ey == 255) return (sx != sy) ? 32'h7FC0_0000 : {sx, 31'h7F80_0000};
    if (ex == 255) return {sx, 31'h7F80_0000};
    if (ey == 255) return {sy, 31'h7F80_0000};
    if (ex == 0 && ey == 0) return {sx & sy, 31'b0};
    mx = (ex == 0) ? 0 : 64'h80_0000 + longint'(x[22:0]);
    my = (ey == 0) ? 0 : 64'h80_0000 + longint'(y[22:0]);
    if (ex > ey || (ex == ey && mx >= my)) begin
      ebig = ex; esml = ey; mbig = mx; msml = my; s = sx;
    end else begin
      ebig = ey; esml = ex; mbig = my; msml = mx; s = sy;
    end
    d = ebig - esml;
    msml = (d >= 26) ? 0 : (msml >> d);
    r = (sx == sy) ? mbig + msml : mbig - msml;
    if (r == 0) return 32'h0;
    e = ebig;
    while (r >= 64'h100_0000) begin r = r >> 1; e++; end
    while (r < 64'h80_0000) begin r = r << 1; e--; end
    if (e >= 255) return {s, 31'h7F80_0000};
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), 23'(r)};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [4:0]  dest;
  } req_t;

  req_t        pend[$];
  int          phase = 0;   // 0 idle, 1..3 working, 4 done state
  bit          exp_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_dest = '0;

  // Timing model: one accepted request, four edges until the write-back.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0;
      exp_done = 1'b0;
      m_result = '0;
      m_dest = '0;
      pend.delete();
    end else begin
      req_t r;
      exp_done = (phase == 4);
      if (phase == 4 && pend.size() > 0) begin
        r = pend.pop_front();
        m_result = fp_model(r.a, r.b, r.op);
        m_dest = r.dest;
      end
      if ((phase == 0 || phase == 4) && start) begin
        r.a = a; r.b = b; r.op = op; r.dest = dest_in;
        pend.push_back(r);
        phase = 1;
      end else if (phase >= 1 && phase <= 3) begin
        phase++;
      end else begin
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", {31'b0, done}, {31'b0, exp_done});
      chk("busy", {31'b0, busy}, {31'b0, (phase >= 1 && phase <= 3)});
      chk("reg_write", {31'b0, reg_write}, {31'b0, exp_done && (m_dest != 0)});
      chk("result", result, m_result);
      chk("dest_out", {27'b0, dest_out}, {27'b0, m_dest});
    end
  end

  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic top, input logic [4:0] td, input logic [31:0] want);
    int lat;
    lat = 99;
    chk({name, " model"}, fp_model(ta, tb_v, top), want);
    @(negedge clk);
    a = ta; b = tb_v; op = top; dest_in = td; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        a = ~ta; b = ~tb_v; op = ~top; dest_in = ~td;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'd5);
    chk({name, " result"}, result, want);
    chk({name, " dest_out"}, {27'b0, dest_out}, {27'b0, td});
    chk({name, " reg_write"}, {31'b0, reg_write}, {31'b0, td != 0});
  endtask

  logic [31:0] va [8] = '{32'h40A0_0000, 32'h3F80_0000, 32'h8000_0000, 32'hC000_0000,
                          32'h4B80_0000, 32'h0080_0001, 32'h7F80_0000, 32'h3FC0_0000};
  logic [31:0] vb [8] = '{32'hC040_0000, 32'h3F00_0000, 32'h8000_0000, 32'h4000_0000,
                          32'h3F80_0000, 32'h0080_0000, 32'h3F80_0000, 32'hBE80_0000};
  logic        vop[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset dest_out", {27'b0, dest_out}, 32'd0);
    chk("reset reg_write", {31'b0, reg_write}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3, 32'h4040_0000);
    run_op("sub_shift", 32'h3FC0_0000, 32'h3E80_0000, 1'b1, 5'd7, 32'h3FA0_0000);
    run_op("sub_dest0", 32'h3FC0_0000, 32'h3E80_0000, 1'b1, 5'd0, 32'h3FA0_0000);
    run_op("cancel", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 5'd1, 32'h0000_0000);
    run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd31, 32'h7F80_0000);
    run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 5'd2, 32'h7FC0_0000);
    run_op("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 5'd4, 32'h7FC0_0000);
    run_op("denormal", 32'h0000_0001, 32'h3F80_0000, 1'b0, 5'd5, 32'h3F80_0000);
    run_op("five_minus_three", 32'h40A0_0000, 32'hC040_0000, 1'b0, 5'd6, 32'h4000_0000);
    run_op("neg_zeros", 32'h8000_0000, 32'h0000_0000, 1'b1, 5'd8, 32'h8000_0000);
    run_op("mixed_zeros", 32'h8000_0000, 32'h0000_0000, 1'b0, 5'd9, 32'h0000_0000);
    run_op("underflow", 32'h0080_0001, 32'h0080_0000, 1'b1, 5'd10, 32'h0000_0000);
    run_op("inf_finite", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 5'd11, 32'hFF80_0000);

    // Back-to-back: start held high, operands churn every cycle.
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = va[i % 8]; b = vb[i % 8]; op = vop[i % 8]; dest_in = 5'(i + 1);
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("b2b done count", 32'(ndone), 32'd4);
    repeat (6) @(negedge clk);

    // Reset while the operation sits in ADD.
    @(negedge clk);
    a = 32'h4040_0000; b = 32'h3F80_0000; op = 1'b0; dest_in = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst dest_out", {27'b0, dest_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst no done", 32'(ndone), 32'd0);
    run_op("after_rst", 32'h4040_0000, 32'h3F80_0000, 1'b0, 5'd12, 32'h4080_0000);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
